cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter BEATS, default 4: 64-bit beats per 256-bit cache line burst.
REQ-002 Parameter ADDR_W, default 32: byte address width.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 ic_addr  input  ADDR_W  I-cache line miss address.
REQ-006 ic_read  input  1  I-cache read request; held high until ic_resp.
REQ-007 ic_rdata  output  256  I-cache fill line.
REQ-008 ic_resp  output  1  one-cycle I-cache completion pulse.
REQ-009 dc_addr  input  ADDR_W  D-cache line address.
REQ-010 dc_read  input  1  D-cache read request; held high until dc_resp.
REQ-011 dc_write  input  1  D-cache writeback request; held high until dc_resp.
REQ-012 dc_wdata  input  256  D-cache writeback line; stable while dc_write is high.
REQ-013 dc_rdata  output  256  D-cache fill line.
REQ-014 dc_resp  output  1  one-cycle D-cache completion pulse.
REQ-015 bmem_addr  output  ADDR_W  line-aligned memory address.
REQ-016 bmem_read  output  1  burst read command.
REQ-017 bmem_write  output  1  write beat valid.
REQ-018 bmem_wdata  output  64  write beat data.
REQ-019 bmem_ready  input  1  memory accepts the command or beat this cycle.
REQ-020 bmem_raddr  input  ADDR_W  address tag of the returning read beat.
REQ-021 bmem_rdata  input  64  read beat data.
REQ-022 bmem_rvalid  input  1  read beat valid.

Function
REQ-023 The FSM SHALL have states IDLE, RD_ISSUE, RD_WAIT, WR_BEAT and RESP, with one memory transaction outstanding at a time.
REQ-024 In IDLE, when one requester is pending it SHALL be granted; when both are pending, grant SHALL alternate round-robin using a last-grant register.
REQ-025 When dc_read and dc_write are both high, the request SHALL be treated as a write.
REQ-026 bmem_addr SHALL be {addr[ADDR_W-1:5], 5'b0} of the granted requester and SHALL be held for the entire transaction.
REQ-027 RD_ISSUE SHALL assert bmem_read until the first cycle bmem_ready is high, then go to RD_WAIT; bmem_read SHALL be high for exactly one accepted cycle.
REQ-028 In RD_WAIT, the n-th beat with bmem_rvalid=1 and bmem_raddr equal to the held bmem_addr SHALL be written to line bits [64n+63:64n], n = 0..BEATS-1 in arrival order.
REQ-029 Beats whose raddr mismatches SHALL be discarded.
REQ-030 After beat BEATS-1 is captured, the FSM SHALL go to RESP.
REQ-031 WR_BEAT SHALL assert bmem_write with bmem_wdata = dc_wdata[64k+63:64k] for beat k.
REQ-032 In WR_BEAT, k SHALL advance only in cycles where bmem_ready=1; while ready is low, write, address and data SHALL be held.
REQ-033 After beat BEATS-1 is accepted, the FSM SHALL go to RESP with no gap cycle between accepted beats when ready stays high.
REQ-034 RESP SHALL last one cycle and pulse the granted requester's resp, with rdata valid in that cycle (reads); the FSM SHALL then return to IDLE.
REQ-035 A request still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-036 ic_rdata and dc_rdata SHALL hold their last completed line until overwritten.
REQ-037 bmem_rvalid in IDLE, RD_ISSUE, WR_BEAT or RESP SHALL be ignored.
REQ-038 Latency from request to resp with ready always high and first beat arriving D cycles after issue SHALL be 1 (grant) + 1 (issue) + D + BEATS-1 + 1 cycles.
REQ-039 Beat and state counters SHALL use $clog2(BEATS)-bit wrap-free counting.

Reset
REQ-040 While rst is high at a clock edge, on that edge: state=IDLE; bmem_read=0, bmem_write=0; bmem_addr=0; bmem_wdata=0; ic_resp=0, dc_resp=0; ic_rdata=0, dc_rdata=0; beat counter=0; last-grant=I-cache (D-cache wins the first tie).
REQ-041 Reset asserted mid-transaction SHALL abort it with no resp, and beats arriving after reset SHALL be discarded.

Verification
REQ-042 I-read 0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x0000_1220, one bmem_read, ic_rdata={beat3,beat2,beat1,beat0}, single ic_resp.
REQ-043 D-write 0x8000_0040 with bmem_ready low on beat 2 for 3 cycles -> 4 accepted beats in order, wdata held during stall, dc_resp once after beat 3.
REQ-044 ic_read and dc_read both asserted from the same cycle after reset -> D-cache served first, I-cache next, alternating thereafter.
REQ-045 Stray rvalid with raddr=0xDEAD_0000 during a read to 0x0000_0100 -> stray beat ignored, line contains only the 4 matching beats.
REQ-046 rst pulsed after 2 read beats -> no resp, outputs at reset values, late beats ignored, next request completes correctly.
REQ-047 dc_read and dc_write both high -> write burst issued, no bmem_read.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin I/D cache line arbiter onto a 64-bit burst memory port
// One transaction at a time; reads gather tagged beats into a line, writebacks stream beats out.
module cache_mem_arbiter #(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ic_addr,
  input  logic                  ic_read,
  output logic [64*BEATS-1:0]   ic_rdata,
  output logic                  ic_resp,
  input  logic [ADDR_W-1:0]     dc_addr,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [64*BEATS-1:0]   dc_wdata,
  output logic [64*BEATS-1:0]   dc_rdata,
  output logic                  dc_resp,
  output logic [ADDR_W-1:0]     bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [63:0]           bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_W-1:0]     bmem_raddr,
  input  logic [63:0]           bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BEAT, RESP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        beat_cnt;
  logic                 grant_dc, last_dc;
  logic [64*BEATS-1:0]  line_buf, line_nxt;
  logic                 ic_pend, dc_pend, pick_dc;
  logic                 beat_last, beat_hit;
  logic [ADDR_W-1:0]    sel_addr;

  // On a tie, the requester that did not win last time is granted.
  assign ic_pend   = ic_read;
  assign dc_pend   = dc_read | dc_write;
  assign pick_dc   = dc_pend & (~ic_pend | ~last_dc);
  assign sel_addr  = pick_dc ? dc_addr : ic_addr;
  assign beat_last = (beat_cnt == CW'(BEATS - 1));
  assign beat_hit  = bmem_rvalid & (bmem_raddr == bmem_addr);

  always_comb begin
    state_nxt  = state;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    ic_resp    = 1'b0;
    dc_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (ic_pend || dc_pend)
          state_nxt = (pick_dc && dc_write) ? WR_BEAT : RD_ISSUE;
      end
      RD_ISSUE: begin
        bmem_read = 1'b1;
        if (bmem_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (beat_hit && beat_last) state_nxt = RESP;
      end
      WR_BEAT: begin
        bmem_write = 1'b1;
        if (bmem_ready && beat_last) state_nxt = RESP;
      end
      RESP: begin
        ic_resp   = ~grant_dc;
        dc_resp   = grant_dc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat slot selection shared by the read gather and the write scatter.
  always_comb begin
    bmem_wdata = '0;
    line_nxt   = line_buf;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_cnt == CW'(i)) begin
        line_nxt[64*i +: 64] = bmem_rdata;
        if (state == WR_BEAT) bmem_wdata = dc_wdata[64*i +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      grant_dc  <= 1'b0;
      last_dc   <= 1'b0;
      bmem_addr <= '0;
      line_buf  <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ic_pend || dc_pend) begin
            grant_dc  <= pick_dc;
            last_dc   <= pick_dc;
            bmem_addr <= {sel_addr[ADDR_W-1:5], 5'b0};
            beat_cnt  <= '0;
          end
        end
        RD_WAIT: begin
          if (beat_hit) begin
            line_buf <= line_nxt;
            beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
            // Publish the completed line so it is valid during RESP.
            if (beat_last) begin
              if (grant_dc) dc_rdata <= line_nxt;
              else          ic_rdata <= line_nxt;
            end
          end
        end
        WR_BEAT: begin
          if (bmem_ready) beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed table-driven bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ic_addr, dc_addr, bmem_addr, bmem_raddr;
  logic         ic_read, ic_resp, dc_read, dc_write, dc_resp;
  logic [255:0] ic_rdata, dc_rdata, dc_wdata;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.BEATS(BEATS), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ic_addr(ic_addr), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_addr(dc_addr), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  typedef struct {
    logic        is_dc;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] seed;
    int          d;
    int          stall_beat;
    int          stall_len;
    logic        stray;
    logic [31:0] exp_addr;
  } txn_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [255:0] last_ic = '0;
  logic [255:0] last_dc = '0;
  txn_t         tv[7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat(input logic [31:0] seed, input int j);
    if (seed == 32'h0) return 64'h1111_1111_1111_1111 * 64'(j + 1);
    return {seed + 32'(j), ~(seed + 32'(j))};
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int j = 0; j < BEATS; j++) l[64*j +: 64] = mk_beat(seed, j);
    return l;
  endfunction

  task automatic idle_inputs();
    ic_read = 0; dc_read = 0; dc_write = 0;
    bmem_ready = 1; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(negedge clk);
    rst = 0;
    last_ic = '0; last_dc = '0;
  endtask

  task automatic do_txn(input txn_t t, input string tag);
    logic         is_w;
    logic [255:0] line;
    logic         issued;
    int           k, nrd, ci, stall_cnt, rsp_c, lat_exp, rel, j, cur;
    is_w = t.is_dc & t.wr;
    line = mk_line(t.seed);
    issued = 0; k = 0; nrd = 0; ci = -1; stall_cnt = 0; rsp_c = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (t.is_dc) begin
          dc_addr = t.addr; dc_read = t.rd; dc_write = t.wr; dc_wdata = line;
        end else begin
          ic_addr = t.addr; ic_read = 1;
        end
      end
      cur = is_w ? k : (issued ? -1 : 0);
      bmem_ready = 1;
      if (c > 0 && cur == t.stall_beat && stall_cnt < t.stall_len) begin
        bmem_ready = 0;
        stall_cnt++;
      end
      bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
      if (!is_w) begin
        if (!issued) begin
          // matching-tag beat that arrives before the read is accepted must be ignored
          bmem_rvalid = 1; bmem_raddr = t.exp_addr; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
          rel = c - ci - t.d;
          j   = rel - (t.stray ? 1 : 0);
          if (t.stray && rel == 0) begin
            bmem_rvalid = 1; bmem_raddr = 32'hDEAD_0000; bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
          end else if (j >= 0 && j < BEATS) begin
            bmem_rvalid = 1; bmem_raddr = t.exp_addr; bmem_rdata = mk_beat(t.seed, j);
          end
        end
      end
      #1;
      if (bmem_read) begin
        chk({tag, " rd_addr"}, bmem_addr, t.exp_addr);
        if (bmem_ready) begin nrd++; issued = 1; ci = c; end
      end
      if (bmem_write) begin
        chk({tag, " wr_addr"}, bmem_addr, t.exp_addr);
        if (k < BEATS) chk({tag, " wdata"}, bmem_wdata, line[64*k +: 64]);
        if (bmem_ready) k++;
      end
      if (ic_resp || dc_resp) begin
        rsp_c = c;
        chk({tag, " resp_side"}, {ic_resp, dc_resp}, t.is_dc ? 2'b01 : 2'b10);
        break;
      end
    end
    if (rsp_c < 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got no resp expected resp", tag);
    end else begin
      lat_exp = (is_w ? BEATS + 2 : t.d + BEATS + 2)
              + ((is_w ? (t.stall_beat < BEATS) : (t.stall_beat == 0)) ? t.stall_len : 0)
              + ((t.stray && !is_w) ? 1 : 0);
      chk({tag, " latency"}, rsp_c + 1, lat_exp);
      chk({tag, " n_reads"}, nrd, is_w ? 0 : 1);
      if (is_w) chk({tag, " n_wbeats"}, k, BEATS);
      if (!t.is_dc) last_ic = line;
      else if (!is_w) last_dc = line;
      chk({tag, " ic_rdata"}, ic_rdata, last_ic);
      chk({tag, " dc_rdata"}, dc_rdata, last_dc);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, " resp_one_cycle"}, {ic_resp, dc_resp}, 2'b00);
    chk({tag, " idle_cmd"}, {bmem_read, bmem_write}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  order;
    logic [31:0] iss_addr, first_addr;
    logic        any_resp;
    int          ci, nresp, j;

    rst = 1; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    idle_inputs();
    //             is_dc rd wr addr           seed           d  sb  sl stray exp_addr
    tv[0] = '{1'b0, 1, 0, 32'h0000_1234, 32'h0,         1, 9,  0, 0, 32'h0000_1220};
    tv[1] = '{1'b1, 0, 1, 32'h8000_0040, 32'hA5A5_0000, 1, 2,  3, 0, 32'h8000_0040};
    tv[2] = '{1'b0, 1, 0, 32'h0000_0100, 32'h0100_0000, 2, 9,  0, 1, 32'h0000_0100};
    tv[3] = '{1'b1, 1, 0, 32'h1234_567F, 32'h5555_0000, 3, 0,  2, 0, 32'h1234_5660};
    tv[4] = '{1'b1, 1, 1, 32'h0000_0FFF, 32'h7777_0000, 1, 9,  0, 0, 32'h0000_0FE0};
    tv[5] = '{1'b1, 0, 1, 32'h7FFF_FFE0, 32'h3C3C_0000, 1, 9,  0, 0, 32'h7FFF_FFE0};
    tv[6] = '{1'b0, 1, 0, 32'hFFFF_FFFF, 32'h9999_0000, 1, 9,  0, 0, 32'hFFFF_FFE0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst bmem_read", bmem_read, 1'b0);
    chk("rst bmem_write", bmem_write, 1'b0);
    chk("rst bmem_addr", bmem_addr, 32'h0);
    chk("rst bmem_wdata", bmem_wdata, 64'h0);
    chk("rst resp", {ic_resp, dc_resp}, 2'b00);
    chk("rst ic_rdata", ic_rdata, 256'h0);
    chk("rst dc_rdata", dc_rdata, 256'h0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) do_txn(tv[i], $sformatf("vec%0d", i));

    // Simultaneous reads straight after reset: D first, then strict alternation.
    do_reset();
    @(negedge clk);
    ic_addr = 32'h0000_3000; dc_addr = 32'h0000_4000; ic_read = 1; dc_read = 1;
    ci = -1; nresp = 0; order = '0; iss_addr = '0; first_addr = '0;
    for (int c = 0; c < 120 && nresp < 4; c++) begin
      if (c > 0) @(negedge clk);
      bmem_ready = 1; bmem_rvalid = 0;
      if (ci >= 0) begin
        j = c - ci - 1;
        if (j >= 0 && j < BEATS) begin
          bmem_rvalid = 1; bmem_raddr = iss_addr; bmem_rdata = mk_beat(iss_addr, j);
        end
      end
      #1;
      if (bmem_read) begin
        ci = c; iss_addr = bmem_addr;
        if (nresp == 0) first_addr = bmem_addr;
      end
      if (ic_resp || dc_resp) begin
        order[nresp] = dc_resp;
        nresp++;
      end
    end
    @(negedge clk);
    idle_inputs();
    chk("tie n_resp", nresp, 4);
    chk("tie first_addr", first_addr, 32'h0000_4000);
    chk("tie order", order, 4'b0101);

    // Reset after two captured beats aborts the read; later beats must not land.
    @(negedge clk);
    ic_addr = 32'h0000_2000; ic_read = 1; bmem_ready = 1;
    any_resp = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      bmem_rvalid = 0; rst = (c == 4);
      if (c == 4) ic_read = 0;
      if (c >= 2 && c <= 5) begin
        bmem_rvalid = 1; bmem_raddr = 32'h0000_2000; bmem_rdata = mk_beat(32'h2000, c - 2);
      end
      #1;
      any_resp = any_resp | ic_resp | dc_resp;
      if (c == 1) chk("abort issue", bmem_read, 1'b1);
      if (c == 5) begin
        chk("abort bmem_read", bmem_read, 1'b0);
        chk("abort bmem_write", bmem_write, 1'b0);
        chk("abort bmem_addr", bmem_addr, 32'h0);
        chk("abort bmem_wdata", bmem_wdata, 64'h0);
        chk("abort ic_rdata", ic_rdata, 256'h0);
        chk("abort dc_rdata", dc_rdata, 256'h0);
      end
    end
    rst = 0;
    idle_inputs();
    chk("abort no_resp", any_resp, 1'b0);
    last_ic = '0; last_dc = '0;
    do_txn(tv[0], "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
